// File: rtl/de_pipe_reg.sv
// D->E pipeline register for lanes 1/2 with load-use hazard detection, flush and stall hold.
// Optional load-use stall counter enabled by defining DE_STALL_CNT_EN.
module de_pipe_reg #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushE,
  input  logic              stall_in,
  input  logic              validD1,
  input  logic              validD2,
  input  logic [4:0]        rs1D1,
  input  logic [4:0]        rs2D1,
  input  logic [4:0]        rs1D2,
  input  logic [4:0]        rs2D2,
  input  logic [4:0]        rdD1,
  input  logic [4:0]        rdD2,
  input  logic              use1D1,
  input  logic              use2D1,
  input  logic              use1D2,
  input  logic              use2D2,
  input  logic [31:0]       source1D1,
  input  logic [31:0]       source2D1,
  input  logic [31:0]       source1D2,
  input  logic [31:0]       source2D2,
  input  logic              reg_writeD1,
  input  logic              reg_writeD2,
  input  logic [2:0]        mem_loadD1,
  input  logic [2:0]        mem_loadD2,
  input  logic [CTRL_W-1:0] ctrlD1,
  input  logic [CTRL_W-1:0] ctrlD2,
  input  logic [4:0]        rdM1,
  input  logic [4:0]        rdM2,
  input  logic              reg_writeM1,
  input  logic              reg_writeM2,
  input  logic [2:0]        mem_loadM1,
  input  logic [2:0]        mem_loadM2,
  output logic              stallD,
  output logic              validE1,
  output logic              validE2,
  output logic [4:0]        rs1E1,
  output logic [4:0]        rs2E1,
  output logic [4:0]        rs1E2,
  output logic [4:0]        rs2E2,
  output logic [4:0]        rdE1,
  output logic [4:0]        rdE2,
  output logic [31:0]       source1E1,
  output logic [31:0]       source2E1,
  output logic [31:0]       source1E2,
  output logic [31:0]       source2E2,
  output logic              reg_writeE1,
  output logic              reg_writeE2,
  output logic [2:0]        mem_loadE1,
  output logic [2:0]        mem_loadE2,
  output logic [CTRL_W-1:0] ctrlE1,
  output logic [CTRL_W-1:0] ctrlE2,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       src1;
    logic [31:0]       src2;
    logic              reg_write;
    logic [2:0]        mem_load;
    logic [CTRL_W-1:0] ctrl;
  } lane_t;

  lane_t      lane1_p0, lane2_p0;
  lane_t      lane1_p1, lane2_p1;
  logic [3:0] prod;
  logic [3:0][4:0] prod_rd;
  logic       hazard;

  // An operand depends on a load only if it is actually read and names a live, nonzero load rd.
  function automatic logic dep(input logic [4:0] rs, input logic use_rs,
                               input logic [3:0] p, input logic [3:0][4:0] prd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (p[k] && (prd[k] == rs)) hit = 1'b1;
    end
    return use_rs && hit;
  endfunction

  function automatic lane_t capture(input lane_t d);
    lane_t q;
    q = d;
    if (!q.valid) begin
      q.reg_write = 1'b0;
      q.mem_load  = 3'b000;
    end
    return q;
  endfunction

  // ---- stage p0: D-side bundle and hazard detection ----
  assign lane1_p0 = '{valid: validD1, rs1: rs1D1, rs2: rs2D1, rd: rdD1, src1: source1D1,
                      src2: source2D1, reg_write: reg_writeD1, mem_load: mem_loadD1, ctrl: ctrlD1};
  assign lane2_p0 = '{valid: validD2, rs1: rs1D2, rs2: rs2D2, rd: rdD2, src1: source1D2,
                      src2: source2D2, reg_write: reg_writeD2, mem_load: mem_loadD2, ctrl: ctrlD2};

  assign prod[0] = lane1_p1.valid && lane1_p1.reg_write && (lane1_p1.mem_load != 3'b000) && (lane1_p1.rd != 5'd0);
  assign prod[1] = lane2_p1.valid && lane2_p1.reg_write && (lane2_p1.mem_load != 3'b000) && (lane2_p1.rd != 5'd0);
  assign prod[2] = reg_writeM1 && (mem_loadM1 != 3'b000) && (rdM1 != 5'd0);
  assign prod[3] = reg_writeM2 && (mem_loadM2 != 3'b000) && (rdM2 != 5'd0);
  assign prod_rd = {rdM2, rdM1, lane2_p1.rd, lane1_p1.rd};

  assign hazard = (validD1 && (dep(rs1D1, use1D1, prod, prod_rd) || dep(rs2D1, use2D1, prod, prod_rd))) ||
                  (validD2 && (dep(rs1D2, use1D2, prod, prod_rd) || dep(rs2D2, use2D2, prod, prod_rd)));

  assign stallD = !flushE && (stall_in || hazard);

  // ---- stage p1: E registers ----
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      lane1_p1 <= '0;
      lane2_p1 <= '0;
    end else if (stall_in) begin
      lane1_p1 <= lane1_p1;
      lane2_p1 <= lane2_p1;
    end else if (hazard) begin
      lane1_p1 <= '0;
      lane2_p1 <= '0;
    end else begin
      lane1_p1 <= capture(lane1_p0);
      lane2_p1 <= capture(lane2_p0);
    end
  end

  assign validE1     = lane1_p1.valid;
  assign rs1E1       = lane1_p1.rs1;
  assign rs2E1       = lane1_p1.rs2;
  assign rdE1        = lane1_p1.rd;
  assign source1E1   = lane1_p1.src1;
  assign source2E1   = lane1_p1.src2;
  assign reg_writeE1 = lane1_p1.reg_write;
  assign mem_loadE1  = lane1_p1.mem_load;
  assign ctrlE1      = lane1_p1.ctrl;
  assign validE2     = lane2_p1.valid;
  assign rs1E2       = lane2_p1.rs1;
  assign rs2E2       = lane2_p1.rs2;
  assign rdE2        = lane2_p1.rd;
  assign source1E2   = lane2_p1.src1;
  assign source2E2   = lane2_p1.src2;
  assign reg_writeE2 = lane2_p1.reg_write;
  assign mem_loadE2  = lane2_p1.mem_load;
  assign ctrlE2      = lane2_p1.ctrl;

`ifdef DE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_p1;

  // Only cycles where the hazard itself is the reason for the bubble are counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (hazard && !flushE && !stall_in) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_p1;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D→E pipeline register for the dual-issue RV32I core, lanes 1 and 2. It sits directly upstream of the E-stage forwarding unit and supplies that unit's rs/source operands.
- Detects load-use hazards. The E-stage forwarder never forwards a load from M, so a consumer in D must wait while the producing load is in E or M.
- Inserts bubbles on a load-use hazard or a flush, and holds its contents on a downstream stall.

Parameters:
- CTRL_W, 16, width of the opaque per-lane control bundle (ALU op, imm select, branch bits) carried D→E unchanged.
- CNT_W, 32, width of the stall performance counter (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flushE  in  1  redirect/mispredict: kill the D→E transfer
- stall_in  in  1  downstream (M/memory) stall: hold the E registers
- validD1, validD2  in  1  D lane holds a real instruction
- rs1D1, rs2D1, rs1D2, rs2D2, rdD1, rdD2  in  5  register indices
- use1D1, use2D1, use1D2, use2D2  in  1  lane actually reads rs1/rs2
- source1D1, source2D1, source1D2, source2D2  in  32  register-file read data
- reg_writeD1, reg_writeD2  in  1  lane writes rd
- mem_loadD1, mem_loadD2  in  3  load type; 3'b000 = not a load
- ctrlD1, ctrlD2  in  CTRL_W  control bundle
- rdM1, rdM2  in  5  M-stage destinations
- reg_writeM1, reg_writeM2  in  1  M-stage write enables
- mem_loadM1, mem_loadM2  in  3  M-stage load types
- stallD  out  1  hold IF/ID this cycle (combinational)
- validE1, validE2, rs1E1, rs2E1, rs1E2, rs2E2, rdE1, rdE2, source1E1, source2E1, source1E2, source2E2, reg_writeE1, reg_writeE2, mem_loadE1, mem_loadE2, ctrlE1, ctrlE2  out  as D counterparts  registered E-stage copies
- stall_cnt  out  CNT_W  load-use stall cycles (only with the macro)

Behaviour:
- Producer E lane k: validEk & reg_writeEk & mem_loadEk≠0 & rdEk≠0. Producer M lane k: reg_writeMk & mem_loadMk≠0 & rdMk≠0.
- hazard = any validDj lane with (use1Dj & rs1Dj matches the rd of any producer) or (use2Dj & rs2Dj matches the rd of any producer). Four producers, four consumer operands, no x0 match.
- Each E register updates on posedge clk with the priority rst > flushE > stall_in > hazard > load:
  - rst: every E output is 0, so both lanes are bubbles.
  - flushE: both lanes become bubbles (valid, reg_write, mem_load, rd, rs, ctrl = 0; sources = 0).
  - stall_in: all E registers hold.
  - hazard: both lanes become bubbles; the D bundle is kept by upstream via stallD.
  - Otherwise: copy D to E. An invalid D lane is captured as a bubble (reg_write and mem_load forced to 0).
- stallD = ~flushE & (stall_in | hazard). With flushE asserted, stallD = 0 regardless of hazard.
- Latency: D→E is 1 cycle.
  - Load in E, consumer in D: 2 bubbles total (one while the load is in E, one while it is in M). The consumer enters E when the load reaches W.
  - Load in M, consumer in D: 1 bubble.
- Dual-lane hazards: both lanes stall together. No lane splitting: one lane hazardous bubbles the whole bundle.
- Intra-bundle D1→D2 dependence is excluded here; issue logic never pairs such instructions.
- Reset mid-stall: the E registers clear and stallD drops the next cycle. This applies unless M inputs (already reset upstream) still hold loads.

Optional Feature:
- Macro: DE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each cycle with hazard & ~flushE & ~stall_in & ~rst.
  - Wraps at 2^CNT_W−1 → 0.
  - Clears on rst.
- Undefined: the port is still present and tied to 0. No counter flops exist.

Test Plan:
- Reset 1 cycle with arbitrary D inputs → all E outputs 0, stallD=0; the next cycle loads D (validD1=1, rdD1=5, source1D1=32'h1234) into E.
- Lane1 lw x5 reaches E; next D lane2 reads rs1=5 with use1=1 → stallD=1 for 2 cycles, 2 bubbles in E (validE=0, reg_writeE=0). The consumer enters E on the 3rd cycle.
- rdM1=7, reg_writeM1=1, mem_loadM1=3'b010; D lane1 rs2=7 with use2=1 → exactly 1 bubble. With mem_loadM1=3'b000 instead → 0 bubbles.
- Hazard against x0: producer rd=0 load, consumer rs1=0 → stallD=0, no bubble. Same hazard with use1=0 → no stall.
- Hazard and flushE in the same cycle → E bubbles, stallD=0. stall_in=1 for 3 cycles → E values unchanged, stallD=1.
- With DE_STALL_CNT_EN: 2-bubble load-use scenario → stall_cnt 0→2. Preload the counter near 2^CNT_W−1, trigger 2 stalls → wraps to 1. Without the macro → stall_cnt stays 0.
